// File: rtl/delay_launch_ctrl_if.sv
// ---------------------------------------------------------------------------
// DelayLaunchCtrl stream interface
//
// Purpose: bundles the upstream (in_*) and downstream (out_*) valid/ready
// token handshakes of delay_launch_ctrl into one connection.
//
// Signals:
//   in_valid  - upstream token valid            (master -> slave)
//   in_ready  - slave can accept a token        (slave  -> master)
//   in_data   - upstream token, WIDTH bits      (master -> slave)
//   out_valid - downstream token valid          (slave  -> master)
//   out_ready - downstream accepts              (master -> slave)
//   out_data  - captured token, WIDTH bits      (slave  -> master)
//
// Modports:
//   master - the environment: produces input tokens, consumes output tokens
//   slave  - the controller itself
// ---------------------------------------------------------------------------
interface delay_launch_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/delay_launch_ctrl.sv
// ---------------------------------------------------------------------------
// delay_launch_ctrl
//
// Purpose: launches one data token at a time through an external
// self-timed unit-delay chain using two-phase signalling. Accepting a token
// toggles dly_req; the token is released downstream once the synchronized
// return (ack_s) has caught up with dly_req. If the chain does not return
// within TIMEOUT cycles a sticky error is raised and the token is dropped.
//
// Parameters:
//   WIDTH   - token width (default 8)
//   TIMEOUT - cycles allowed in WAIT before declaring an error (4..255)
//
// Ports:
//   clk         - clock, all flops rising-edge
//   rstn        - asynchronous active-low reset
//   bus         - slave side of the in/out token handshakes
//   dly_req     - two-phase request into the delay chain inR
//   dly_ack     - delayed request from the chain outR (async to clk)
//   timeout_err - sticky chain-timeout flag
//   err_clr     - clears timeout_err and leaves ERR (ignored elsewhere)
// ---------------------------------------------------------------------------
module delay_launch_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    delay_launch_ctrl_if.slave     bus,
    output logic                   dly_req,
    input  logic                   dly_ack,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        ERR  = 2'b11
    } stateT;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    stateT            state;
    stateT            stateNext;
    logic             dlyReq;
    logic             ackMeta;
    logic             ackSync;
    logic [7:0]       cycleCnt;
    logic [WIDTH-1:0] dataReg;
    logic             timeoutErr;

    logic             captureToken;
    logic             countCycle;
    logic             setErr;
    logic             clearErr;
    logic             ackMatch;
    logic             cntHit;

    // dly_ack comes from a self-timed chain, so it only enters the clocked
    // logic through this two-flop synchronizer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ackMeta <= 1'b0;
            ackSync <= 1'b0;
        end else begin
            ackMeta <= dly_ack;
            ackSync <= ackMeta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Two-phase completion: the flight is over once the returned phase equals
    // the launched phase. A match takes priority over an expiring counter so a
    // chain that returns on the last allowed cycle is not reported as failed.
    assign ackMatch = (ackSync == dlyReq);
    assign cntHit   = (cycleCnt >= TimeoutLast);

    always_comb begin
        stateNext    = state;
        captureToken = 1'b0;
        countCycle   = 1'b0;
        setErr       = 1'b0;
        clearErr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    captureToken = 1'b1;
                    stateNext    = WAIT;
                end
            end
            WAIT: begin
                countCycle = 1'b1;
                if (ackMatch) begin
                    stateNext = HOLD;
                end else if (cntHit) begin
                    setErr    = 1'b1;
                    stateNext = ERR;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            ERR: begin
                if (err_clr) begin
                    clearErr  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Launch phase, token capture and the flight counter. Leaving ERR copies
    // the synchronized return phase into dlyReq so the next launch starts from
    // a realigned phase even though the lost flight never completed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dlyReq   <= 1'b0;
            cycleCnt <= 8'd0;
            dataReg  <= '0;
        end else begin
            if (captureToken) begin
                dataReg  <= bus.in_data;
                dlyReq   <= ~dlyReq;
                cycleCnt <= 8'd0;
            end else if (countCycle) begin
                if (cycleCnt != 8'hFF) begin
                    cycleCnt <= cycleCnt + 8'd1;
                end
            end
            if (clearErr) begin
                dlyReq <= ackSync;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timeoutErr <= 1'b0;
        end else if (setErr) begin
            timeoutErr <= 1'b1;
        end else if (clearErr) begin
            timeoutErr <= 1'b0;
        end
    end

    // Handshake outputs depend on state only, so in_valid/out_ready never
    // reach in_ready/out_valid combinationally.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = dataReg;
    assign dly_req       = dlyReq;
    assign timeout_err   = timeoutErr;

endmodule

// File: tb/tb_delay_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_launch_ctrl
//
// Purpose: directed self-checking bench for delay_launch_ctrl. A behavioural
// delay chain returns dly_req half a cycle later; it can be bypassed with a
// manually driven ack for the timeout and race scenarios.
// ---------------------------------------------------------------------------
module tb_delay_launch_ctrl;

    logic clk;
    logic rstn;
    logic dly_req;
    logic dly_ack;
    logic timeout_err;
    logic err_clr;

    logic chainAck;
    logic chainEnable;
    logic manualAck;

    int checks;
    int errors;

    delay_launch_ctrl_if #(.WIDTH(8)) bus ();

    delay_launch_ctrl #(
        .WIDTH   (8),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .dly_req     (dly_req),
        .dly_ack     (dly_ack),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural delay chain: the request comes back half a cycle later.
    initial chainAck = 1'b0;
    always @(dly_req) begin
        #5;
        chainAck = dly_req;
    end

    assign dly_ack = chainEnable ? chainAck : manualAck;

    task automatic applyStimulus(input logic inValid, input logic [7:0] inData,
                                 input logic outReady, input logic errClr);
        bus.in_valid  = inValid;
        bus.in_data   = inData;
        bus.out_ready = outReady;
        err_clr       = errClr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Reset held across a few edges so the chain model settles, released
    // between edges, then aligned to just after the next rising edge.
    task automatic pulseReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        rstn = 1'b1;
        waitCycle();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        chainEnable = 1'b1;
        manualAck   = 1'b0;
        rstn        = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // ---- Reset state ----
        pulseReset();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'h00);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_dly_req", 32'(dly_req), 32'd0);

        // ---- Single token 0xA5 ----
        $display("[TB] single token");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_dly_req_launch", 32'(dly_req), 32'd1);
        checkOutput("single_in_ready_e0", 32'(bus.in_ready), 32'd0);
        waitCycle();
        checkOutput("single_out_valid_e1", 32'(bus.out_valid), 32'd0);
        waitCycle();
        checkOutput("single_out_valid_e2", 32'(bus.out_valid), 32'd0);
        waitCycle();
        checkOutput("single_out_valid_e3", 32'(bus.out_valid), 32'd1);
        checkOutput("single_out_data_e3", 32'(bus.out_data), 32'hA5);
        checkOutput("single_in_ready_e3", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("single_out_valid_done", 32'(bus.out_valid), 32'd0);
        checkOutput("single_in_ready_done", 32'(bus.in_ready), 32'd1);

        // ---- Back-to-back 0x01 then 0x02 with out_ready held ----
        $display("[TB] back-to-back");
        pulseReset();
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
        waitCycle();
        checkOutput("b2b_dly_req_first", 32'(dly_req), 32'd1);
        applyStimulus(1'b1, 8'h02, 1'b1, 1'b0);
        waitCycle();
        waitCycle();
        checkOutput("b2b_in_ready_wait", 32'(bus.in_ready), 32'd0);
        waitCycle();
        checkOutput("b2b_out_valid_first", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_out_data_first", 32'(bus.out_data), 32'h01);
        waitCycle();
        checkOutput("b2b_out_valid_gap", 32'(bus.out_valid), 32'd0);
        checkOutput("b2b_in_ready_gap", 32'(bus.in_ready), 32'd1);
        checkOutput("b2b_dly_req_gap", 32'(dly_req), 32'd1);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("b2b_dly_req_second", 32'(dly_req), 32'd0);
        waitCycle();
        waitCycle();
        checkOutput("b2b_out_valid_wait2", 32'(bus.out_valid), 32'd0);
        waitCycle();
        checkOutput("b2b_out_valid_second", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_out_data_second", 32'(bus.out_data), 32'h02);
        waitCycle();
        checkOutput("b2b_in_ready_end", 32'(bus.in_ready), 32'd1);

        // ---- Backpressure: 0x3C held for 5 cycles ----
        $display("[TB] backpressure");
        pulseReset();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) waitCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_out_data", 32'(bus.out_data), 32'h3C);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            waitCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bp_release", 32'(bus.in_ready), 32'd1);

        // ---- Timeout with ack tied low ----
        $display("[TB] timeout");
        chainEnable = 1'b0;
        manualAck   = 1'b0;
        pulseReset();
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_dly_req_launch", 32'(dly_req), 32'd1);
        repeat (2) waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_errclr_ignored_wait", 32'(bus.in_ready), 32'd0);
        repeat (11) waitCycle();
        checkOutput("to_err_e14", 32'(timeout_err), 32'd0);
        waitCycle();
        checkOutput("to_err_e15", 32'(timeout_err), 32'd1);
        checkOutput("to_in_ready_err", 32'(bus.in_ready), 32'd0);
        checkOutput("to_out_valid_err", 32'(bus.out_valid), 32'd0);
        waitCycle();
        checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_err_cleared", 32'(timeout_err), 32'd0);
        checkOutput("to_dly_req_realigned", 32'(dly_req), 32'd0);
        checkOutput("to_in_ready_cleared", 32'(bus.in_ready), 32'd1);

        // ---- Race: ack matches on the counter's last cycle ----
        $display("[TB] match/timeout race");
        manualAck = 1'b0;
        pulseReset();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (12) waitCycle();
        manualAck = 1'b1;
        waitCycle();
        waitCycle();
        checkOutput("race_out_valid_e14", 32'(bus.out_valid), 32'd0);
        waitCycle();
        checkOutput("race_out_valid_e15", 32'(bus.out_valid), 32'd1);
        checkOutput("race_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("race_out_data", 32'(bus.out_data), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("race_back_idle", 32'(bus.in_ready), 32'd1);

        // ---- Reset in the middle of a flight ----
        $display("[TB] reset mid-flight");
        manualAck   = 1'b0;
        chainEnable = 1'b1;
        pulseReset();
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        waitCycle();
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_out_data", 32'(bus.out_data), 32'h00);
        checkOutput("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("mid_rst_dly_req", 32'(dly_req), 32'd0);
        @(posedge clk);
        #4;
        rstn = 1'b1;
        waitCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("mid_no_spurious", 32'(bus.out_valid), 32'd0);
            waitCycle();
        end
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("mid_new_dly_req", 32'(dly_req), 32'd1);
        repeat (3) waitCycle();
        checkOutput("mid_new_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mid_new_out_data", 32'(bus.out_data), 32'h99);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        waitCycle();
        checkOutput("mid_new_done", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
